// File: rtl/bypass_buff_mp.sv
// ---------------------------------------------------------------------------
// bypass_buff_mp: multi-source write-back bypass buffer for the TPU operand
// path. Keeps the most recent BUFF_SIZE write-back results keyed by register
// index and serves NUM_SRC operands from same-cycle forwarding, the buffer,
// or the register file (in that priority).
//
// Optional feature: define BYPASS_BUFF_STAT_EN to add saturating hit/miss
// counters (O_Hit_Cnt / O_Miss_Cnt). Without it those ports do not exist.
// ---------------------------------------------------------------------------

package pkg_tpu;
  localparam int INDEX_W = 5;
  localparam int DATA_W  = 32;
  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [DATA_W-1:0]  data_t;
endpackage

module bypass_buff_mp
  import pkg_tpu::*;
#(
  parameter int BUFF_SIZE = 8,
  parameter int NUM_SRC   = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        I_Stall,
  input  logic                        I_Flush,
  input  logic                        I_Valid,
  input  index_t                      I_WB_Index,
  input  data_t                       I_WB_Data,
  input  index_t                      I_Slice_Len,
  input  logic [NUM_SRC-1:0]          I_Idx_v,
  input  index_t [NUM_SRC-1:0]        I_Idx,
  input  data_t [NUM_SRC-1:0]         I_Src,
  output data_t [NUM_SRC-1:0]         O_Src,
  output logic [NUM_SRC-1:0]          O_Hit,
  output logic                        O_Full,
  output logic                        O_Empty,
`ifdef BYPASS_BUFF_STAT_EN
  output logic [31:0]                 O_Hit_Cnt,
  output logic [31:0]                 O_Miss_Cnt,
`endif
  output logic [$clog2(BUFF_SIZE):0]  O_Num
);

  localparam int PW = $clog2(BUFF_SIZE);
  localparam int NW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic {S_IDLE, S_RUN} slice_state_e;

  // Entry storage; entries are contiguous from rd_ptr (oldest) to wr_ptr.
  logic [BUFF_SIZE-1:0] valid_q, valid_d;
  index_t               idx_q  [BUFF_SIZE];
  index_t               idx_d  [BUFF_SIZE];
  data_t                data_q [BUFF_SIZE];
  data_t                data_d [BUFF_SIZE];
  ptr_t                 wr_ptr_q, wr_ptr_d;
  ptr_t                 rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]        num_q, num_d;

  // Per-source slice tracking.
  slice_state_e         state_q [NUM_SRC];
  slice_state_e         state_d [NUM_SRC];
  index_t               end_q   [NUM_SRC];
  index_t               end_d   [NUM_SRC];

  logic                 any_run_q, any_run_d;
  logic                 clear_evt;
  logic                 wb_hit;
  ptr_t                 wb_pos;

  // Operand lookup: forward, then youngest buffer match, then register file.
  // Scanning oldest-to-youngest lets the last match win.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      O_Src[s] = I_Idx_v[s] ? I_Src[s] : '0;
      O_Hit[s] = 1'b0;
      if (reset && I_Idx_v[s]) begin
        if (I_Valid && (I_WB_Index == I_Idx[s])) begin
          O_Src[s] = I_WB_Data;
          O_Hit[s] = 1'b1;
        end else begin
          for (int k = 0; k < BUFF_SIZE; k++) begin
            if (valid_q[rd_ptr_q + ptr_t'(k)] &&
                (idx_q[rd_ptr_q + ptr_t'(k)] == I_Idx[s])) begin
              O_Src[s] = data_q[rd_ptr_q + ptr_t'(k)];
              O_Hit[s] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Slice FSM next state; a clear fires when the last running source retires.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    any_run_q = 1'b0;
    any_run_d = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      state_d[s] = state_q[s];
      end_d[s]   = end_q[s];
      if (!I_Stall) begin
        case (state_q[s])
          S_IDLE: if (I_Idx_v[s] && (I_Slice_Len != '0)) begin
            state_d[s] = S_RUN;
            end_d[s]   = I_Idx[s] + I_Slice_Len;
          end
          S_RUN: if (I_Idx_v[s] && (I_Idx[s] == end_q[s])) begin
            state_d[s] = S_IDLE;
          end
          default: state_d[s] = S_IDLE;
        endcase
      end
      any_run_q = any_run_q | (state_q[s] == S_RUN);
      any_run_d = any_run_d | (state_d[s] == S_RUN);
    end
    clear_evt = I_Flush | (any_run_q & ~any_run_d);
  end

  // Buffer next state: in-place update, allocate, or evict-oldest.
  always_comb begin
    wb_hit = 1'b0;
    wb_pos = '0;
    for (int k = 0; k < BUFF_SIZE; k++) begin
      if (valid_q[rd_ptr_q + ptr_t'(k)] &&
          (idx_q[rd_ptr_q + ptr_t'(k)] == I_WB_Index)) begin
        wb_hit = 1'b1;
        wb_pos = rd_ptr_q + ptr_t'(k);
      end
    end

    valid_d  = valid_q;
    idx_d    = idx_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    num_d    = num_q;

    if (clear_evt) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      num_d    = '0;
      if (I_Valid) begin
        valid_d[0] = 1'b1;
        idx_d[0]   = I_WB_Index;
        data_d[0]  = I_WB_Data;
        wr_ptr_d   = ptr_t'(1);
        num_d      = NW'(1);
      end
    end else if (I_Valid) begin
      if (wb_hit) begin
        data_d[wb_pos] = I_WB_Data;
      end else if (num_q == NW'(BUFF_SIZE)) begin
        idx_d[rd_ptr_q]  = I_WB_Index;
        data_d[rd_ptr_q] = I_WB_Data;
        wr_ptr_d         = wr_ptr_q + ptr_t'(1);
        rd_ptr_d         = rd_ptr_q + ptr_t'(1);
      end else begin
        valid_d[wr_ptr_q] = 1'b1;
        idx_d[wr_ptr_q]   = I_WB_Index;
        data_d[wr_ptr_q]  = I_WB_Data;
        wr_ptr_d          = wr_ptr_q + ptr_t'(1);
        num_d             = num_q + NW'(1);
      end
    end
  end

  // Control state: valid bits, pointers, count and slice FSMs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      num_q    <= '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        state_q[s] <= S_IDLE;
        end_q[s]   <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      num_q    <= num_d;
      state_q  <= state_d;
      end_q    <= end_d;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clock) begin
    // NOTE: the index/data arrays are deliberately not reset; valid_q gates
    // every read, so resetting them would only add reset fan-out.
    idx_q  <= idx_d;
    data_q <= data_d;
  end

  assign O_Num   = num_q;
  assign O_Full  = (num_q == NW'(BUFF_SIZE));
  assign O_Empty = (num_q == '0);

`ifdef BYPASS_BUFF_STAT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [2:0]  n_hit, n_miss;
  logic [32:0] hit_sum, miss_sum;

  // Saturating hit/miss accounting; frozen by stall, cleared by flush.
  always_comb begin
    n_hit  = '0;
    n_miss = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (I_Idx_v[s]) begin
        if (O_Hit[s]) n_hit  = n_hit + 3'd1;
        else          n_miss = n_miss + 3'd1;
      end
    end
    hit_sum    = {1'b0, hit_cnt_q} + 33'(n_hit);
    miss_sum   = {1'b0, miss_cnt_q} + 33'(n_miss);
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (I_Flush) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (!I_Stall) begin
      hit_cnt_d  = hit_sum[32]  ? '1 : hit_sum[31:0];
      miss_cnt_d = miss_sum[32] ? '1 : miss_sum[31:0];
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign O_Hit_Cnt  = hit_cnt_q;
  assign O_Miss_Cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_bypass_buff_mp.sv
// ---------------------------------------------------------------------------
// Directed testbench for bypass_buff_mp (BUFF_SIZE=4, NUM_SRC=3).
// Inputs change just after the falling edge; outputs are sampled 1ns later,
// well away from the rising edge that updates state.
// ---------------------------------------------------------------------------
module tb_bypass_buff_mp;
  import pkg_tpu::*;

  localparam int B = 4;
  localparam int N = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             I_Stall, I_Flush, I_Valid;
  index_t           I_WB_Index, I_Slice_Len;
  data_t            I_WB_Data;
  logic [N-1:0]     I_Idx_v;
  index_t [N-1:0]   I_Idx;
  data_t [N-1:0]    I_Src;
  data_t [N-1:0]    O_Src;
  logic [N-1:0]     O_Hit;
  logic             O_Full, O_Empty;
  logic [2:0]       O_Num;
`ifdef BYPASS_BUFF_STAT_EN
  logic [31:0]      O_Hit_Cnt, O_Miss_Cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bypass_buff_mp #(.BUFF_SIZE(B), .NUM_SRC(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .I_Stall     (I_Stall),
    .I_Flush     (I_Flush),
    .I_Valid     (I_Valid),
    .I_WB_Index  (I_WB_Index),
    .I_WB_Data   (I_WB_Data),
    .I_Slice_Len (I_Slice_Len),
    .I_Idx_v     (I_Idx_v),
    .I_Idx       (I_Idx),
    .I_Src       (I_Src),
    .O_Src       (O_Src),
    .O_Hit       (O_Hit),
    .O_Full      (O_Full),
    .O_Empty     (O_Empty),
`ifdef BYPASS_BUFF_STAT_EN
    .O_Hit_Cnt   (O_Hit_Cnt),
    .O_Miss_Cnt  (O_Miss_Cnt),
`endif
    .O_Num       (O_Num)
  );

  task automatic idle();
    I_Stall = 0; I_Flush = 0; I_Valid = 0;
    I_WB_Index = '0; I_WB_Data = '0; I_Slice_Len = '0;
    I_Idx_v = '0;
    for (int s = 0; s < N; s++) begin
      I_Idx[s] = '0;
      I_Src[s] = 32'hDEAD_0000 + 32'(s);
    end
  endtask

  task automatic next_cycle();
    @(negedge clock);
    idle();
  endtask

  task automatic write_one(input index_t idx, input data_t data);
    I_Valid = 1; I_WB_Index = idx; I_WB_Data = data;
    next_cycle();
  endtask

  task automatic flush_buf();
    I_Flush = 1;
    next_cycle();
  endtask

  task automatic lookup(input int s, input index_t idx, input data_t rf);
    I_Idx_v[s] = 1'b1; I_Idx[s] = idx; I_Src[s] = rf;
  endtask

  task automatic test_reset();
    reset = 0;
    idle();
    @(negedge clock);
    I_Valid = 1; I_WB_Index = 5'd3; I_WB_Data = 32'h1111;
    lookup(0, 5'd3, 32'hAA);
    I_Idx[1] = 5'd3; I_Src[1] = 32'hBB;
    #1;
    checks++; if (O_Hit !== 3'b000) begin failures++; $display("FAIL rst_hit got=%b exp=000", O_Hit); end
    checks++; if (O_Src[0] !== 32'hAA) begin failures++; $display("FAIL rst_src0 got=%h exp=000000aa", O_Src[0]); end
    checks++; if (O_Src[1] !== 32'h0) begin failures++; $display("FAIL rst_src1 got=%h exp=0", O_Src[1]); end
    checks++; if (O_Num !== 3'd0 || O_Empty !== 1'b1 || O_Full !== 1'b0) begin
      failures++; $display("FAIL rst_state num=%0d empty=%b full=%b exp 0/1/0", O_Num, O_Empty, O_Full); end
`ifdef BYPASS_BUFF_STAT_EN
    checks++; if (O_Hit_Cnt !== 0 || O_Miss_Cnt !== 0) begin
      failures++; $display("FAIL rst_cnt hit=%0d miss=%0d exp 0/0", O_Hit_Cnt, O_Miss_Cnt); end
`endif
    next_cycle();
    reset = 1;
    next_cycle();
    checks++; if (O_Num !== 3'd0) begin failures++; $display("FAIL rst_release_num got=%0d exp=0", O_Num); end
  endtask

  task automatic test_evict();
    flush_buf();
    write_one(5'd1, 32'hA0);
    write_one(5'd2, 32'hB0);
    write_one(5'd3, 32'hC0);
    write_one(5'd4, 32'hD0);
    checks++; if (O_Num !== 3'd4 || O_Full !== 1'b1) begin
      failures++; $display("FAIL fill_full num=%0d full=%b exp 4/1", O_Num, O_Full); end
    write_one(5'd5, 32'hE0);
    checks++; if (O_Num !== 3'd4 || O_Full !== 1'b1) begin
      failures++; $display("FAIL evict_full num=%0d full=%b exp 4/1", O_Num, O_Full); end
    lookup(0, 5'd1, 32'h1234);
    lookup(1, 5'd5, 32'h0);
    lookup(2, 5'd2, 32'h0);
    #1;
    checks++; if (O_Hit !== 3'b110) begin failures++; $display("FAIL evict_hit got=%b exp=110", O_Hit); end
    checks++; if (O_Src[0] !== 32'h1234) begin failures++; $display("FAIL evict_miss_src got=%h exp=00001234", O_Src[0]); end
    checks++; if (O_Src[1] !== 32'hE0) begin failures++; $display("FAIL evict_new_src got=%h exp=000000e0", O_Src[1]); end
    checks++; if (O_Src[2] !== 32'hB0) begin failures++; $display("FAIL evict_keep_src got=%h exp=000000b0", O_Src[2]); end
    next_cycle();
    // Second eviction drops index 2, exercising pointer advance.
    write_one(5'd6, 32'hF0);
    lookup(0, 5'd2, 32'h77);
    lookup(1, 5'd3, 32'h0);
    lookup(2, 5'd6, 32'h0);
    #1;
    checks++; if (O_Hit !== 3'b110 || O_Src[0] !== 32'h77 || O_Src[1] !== 32'hC0 || O_Src[2] !== 32'hF0) begin
      failures++; $display("FAIL evict2 hit=%b src0=%h src1=%h src2=%h exp 110/77/c0/f0", O_Hit, O_Src[0], O_Src[1], O_Src[2]); end
    next_cycle();
  endtask

  task automatic test_duplicate();
    flush_buf();
    write_one(5'd7, 32'h11);
    write_one(5'd7, 32'h22);
    lookup(0, 5'd7, 32'h0);
    #1;
    checks++; if (O_Num !== 3'd1) begin failures++; $display("FAIL dup_num got=%0d exp=1", O_Num); end
    checks++; if (O_Hit[0] !== 1'b1 || O_Src[0] !== 32'h22) begin
      failures++; $display("FAIL dup_src hit=%b got=%h exp 1/00000022", O_Hit[0], O_Src[0]); end
    next_cycle();
  endtask

  task automatic test_forward();
    flush_buf();
    I_Valid = 1; I_WB_Index = 5'd9; I_WB_Data = 32'h55;
    lookup(0, 5'd9, 32'h0);
    I_Idx[1] = 5'd9;
    #1;
    checks++; if (O_Hit[0] !== 1'b1 || O_Src[0] !== 32'h55) begin
      failures++; $display("FAIL fwd_src hit=%b got=%h exp 1/00000055", O_Hit[0], O_Src[0]); end
    checks++; if (O_Hit[1] !== 1'b0 || O_Src[1] !== 32'h0) begin
      failures++; $display("FAIL fwd_novalid hit=%b got=%h exp 0/0", O_Hit[1], O_Src[1]); end
    next_cycle();
    // Forward takes priority over the buffered copy of the same index.
    I_Valid = 1; I_WB_Index = 5'd9; I_WB_Data = 32'h99;
    lookup(0, 5'd9, 32'h0);
    #1;
    checks++; if (O_Src[0] !== 32'h99) begin failures++; $display("FAIL fwd_prio got=%h exp=00000099", O_Src[0]); end
    next_cycle();
  endtask

  task automatic start_slice_and_fill();
    flush_buf();
    lookup(0, 5'd10, 32'h0);
    I_Slice_Len = 5'd3;
    next_cycle();
    write_one(5'd20, 32'h200);
    write_one(5'd21, 32'h210);
    write_one(5'd22, 32'h220);
  endtask

  task automatic test_slice();
    start_slice_and_fill();
    checks++; if (O_Num !== 3'd3) begin failures++; $display("FAIL slice_fill got=%0d exp=3", O_Num); end
    lookup(0, 5'd13, 32'h0);
    lookup(1, 5'd20, 32'h0);
    #1;
    checks++; if (O_Hit[1] !== 1'b1 || O_Src[1] !== 32'h200) begin
      failures++; $display("FAIL slice_preclear hit=%b got=%h exp 1/00000200", O_Hit[1], O_Src[1]); end
    next_cycle();
    checks++; if (O_Num !== 3'd0 || O_Empty !== 1'b1) begin
      failures++; $display("FAIL slice_clear num=%0d empty=%b exp 0/1", O_Num, O_Empty); end

    // Stalled end index does not retire the slice; a mid-slice index does not either.
    start_slice_and_fill();
    lookup(0, 5'd13, 32'h0);
    I_Stall = 1;
    next_cycle();
    checks++; if (O_Num !== 3'd3) begin failures++; $display("FAIL slice_stall got=%0d exp=3", O_Num); end
    lookup(0, 5'd11, 32'h0);
    next_cycle();
    checks++; if (O_Num !== 3'd3) begin failures++; $display("FAIL slice_mid got=%0d exp=3", O_Num); end
    // Retire together with a write: the write survives as the only entry.
    lookup(0, 5'd13, 32'h0);
    I_Valid = 1; I_WB_Index = 5'd30; I_WB_Data = 32'h77;
    next_cycle();
    lookup(0, 5'd30, 32'h0);
    lookup(1, 5'd20, 32'h5);
    #1;
    checks++; if (O_Num !== 3'd1 || O_Hit !== 3'b001 || O_Src[0] !== 32'h77 || O_Src[1] !== 32'h5) begin
      failures++; $display("FAIL slice_keep_wr num=%0d hit=%b src0=%h src1=%h exp 1/001/77/5", O_Num, O_Hit, O_Src[0], O_Src[1]); end
    next_cycle();

    // End index wraps modulo the index width: 30 + 5 -> 3.
    flush_buf();
    lookup(0, 5'd30, 32'h0);
    I_Slice_Len = 5'd5;
    next_cycle();
    write_one(5'd20, 32'h1);
    lookup(0, 5'd3, 32'h0);
    next_cycle();
    checks++; if (O_Num !== 3'd0) begin failures++; $display("FAIL slice_wrap got=%0d exp=0", O_Num); end
  endtask

  task automatic test_flush();
    flush_buf();
    write_one(5'd1, 32'h10);
    write_one(5'd3, 32'h30);
    I_Flush = 1;
    I_Valid = 1; I_WB_Index = 5'd2; I_WB_Data = 32'h22;
    next_cycle();
    lookup(0, 5'd2, 32'h0);
    lookup(1, 5'd1, 32'h0);
    lookup(2, 5'd3, 32'h0);
    #1;
    checks++; if (O_Num !== 3'd1) begin failures++; $display("FAIL flush_num got=%0d exp=1", O_Num); end
    checks++; if (O_Hit !== 3'b001 || O_Src[0] !== 32'h22) begin
      failures++; $display("FAIL flush_hit hit=%b src0=%h exp 001/00000022", O_Hit, O_Src[0]); end
    next_cycle();
  endtask

  task automatic test_reset_mid_slice();
    flush_buf();
    lookup(0, 5'd10, 32'h0);
    I_Slice_Len = 5'd3;
    next_cycle();
    write_one(5'd20, 32'h1);
    reset = 0;
    #1;
    checks++; if (O_Num !== 3'd0 || O_Empty !== 1'b1) begin
      failures++; $display("FAIL rstmid_num num=%0d empty=%b exp 0/1", O_Num, O_Empty); end
    next_cycle();
    reset = 1;
    next_cycle();
    write_one(5'd21, 32'h2);
    // FSM must be IDLE now, so the old end index causes no clear.
    lookup(0, 5'd13, 32'h0);
    next_cycle();
    checks++; if (O_Num !== 3'd1) begin failures++; $display("FAIL rstmid_fsm got=%0d exp=1", O_Num); end
  endtask

`ifdef BYPASS_BUFF_STAT_EN
  task automatic test_stats();
    flush_buf();
    write_one(5'd1, 32'h1);
    write_one(5'd2, 32'h2);
    for (int c = 0; c < 10; c++) begin
      lookup(0, 5'd1, 32'h0);
      lookup(1, 5'd2, 32'h0);
      lookup(2, 5'd3, 32'h0);
      next_cycle();
    end
    checks++; if (O_Hit_Cnt !== 32'd20 || O_Miss_Cnt !== 32'd10) begin
      failures++; $display("FAIL stat_count hit=%0d miss=%0d exp 20/10", O_Hit_Cnt, O_Miss_Cnt); end
    lookup(0, 5'd1, 32'h0);
    lookup(1, 5'd2, 32'h0);
    lookup(2, 5'd3, 32'h0);
    I_Stall = 1;
    next_cycle();
    checks++; if (O_Hit_Cnt !== 32'd20 || O_Miss_Cnt !== 32'd10) begin
      failures++; $display("FAIL stat_stall hit=%0d miss=%0d exp 20/10", O_Hit_Cnt, O_Miss_Cnt); end
    flush_buf();
    checks++; if (O_Hit_Cnt !== 32'd0 || O_Miss_Cnt !== 32'd0) begin
      failures++; $display("FAIL stat_flush hit=%0d miss=%0d exp 0/0", O_Hit_Cnt, O_Miss_Cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_evict();
    test_duplicate();
    test_forward();
    test_slice();
    test_flush();
    test_reset_mid_slice();
`ifdef BYPASS_BUFF_STAT_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bypass_buff_mp.md
# bypass_buff_mp

Multi-source, parametrised write-back bypass buffer for the TPU backend operand path. It holds the most recent BUFF_SIZE write-back results, keyed by register index. Each of NUM_SRC source operands is served from the buffer, from a same-cycle write-back, or from the register file. Compared with the current three-source buffer it adds:
- generic source count;
- same-cycle write-back forwarding;
- in-place update of duplicate indices;
- oldest-entry eviction instead of stalling on full;
- explicit flush;
- optional hit/miss statistics.

## Interface
Parameters:
- BUFF_SIZE, 8, entry count; power of two, ≥2
- NUM_SRC, 3, source operand count; 1..4

Ports (index_t/data_t from pkg_tpu):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- I_Stall  in  1  freezes slice tracking and statistics; does not block writes
- I_Flush  in  1  invalidate all entries
- I_Valid  in  1  write-back valid
- I_WB_Index  in  index_t  write-back index
- I_WB_Data  in  data_t  write-back data
- I_Slice_Len  in  index_t  slice length; 0 = no slice
- I_Idx_v  in  [NUM_SRC]  source index valid
- I_Idx  in  index_t×NUM_SRC  source indices
- I_Src  in  data_t×NUM_SRC  register-file data
- O_Src  out  data_t×NUM_SRC  selected operand data
- O_Hit  out  [NUM_SRC]  operand served from forward or buffer
- O_Full  out  1  O_Num == BUFF_SIZE
- O_Empty  out  1  O_Num == 0
- O_Num  out  $clog2(BUFF_SIZE)+1  valid entry count
- O_Hit_Cnt  out  32  saturating hit count (BYPASS_BUFF_STAT_EN only)
- O_Miss_Cnt  out  32  saturating miss count (BYPASS_BUFF_STAT_EN only)

## Operation
Lookup is combinational. For each source s, O_Src[s] is selected by priority:
1. Forward: I_Valid & I_Idx_v[s] & I_WB_Index==I_Idx[s] → I_WB_Data.
2. Buffer match: valid entry with index == I_Idx[s] and I_Idx_v[s] → that entry's data. If several entries match, the youngest wins.
3. Otherwise: I_Idx_v[s] ? I_Src[s] : 0.

O_Hit[s] is 1 for cases 1 and 2.

Write (I_Valid, regardless of I_Stall):
- Index already present: overwrite data in place; pointers and O_Num unchanged.
- Index not present and not full: allocate at Wr_Ptr; Wr_Ptr+1; O_Num+1.
- Index not present and full: overwrite the oldest entry at Rd_Ptr; Wr_Ptr+1 and Rd_Ptr+1; O_Num stays BUFF_SIZE.
- Pointers wrap modulo BUFF_SIZE.

Per-source slice FSM, states IDLE and RUN; all transitions require ~I_Stall:
- IDLE→RUN on I_Idx_v[s] & I_Slice_Len≠0. Latch End[s] = I_Idx[s]+I_Slice_Len, truncated to index_t (wraps).
- RUN→IDLE on I_Idx_v[s] & I_Idx[s]==End[s].
- I_Slice_Len is ignored while in RUN.

Clear event: I_Flush, or the cycle in which the last RUN source returns to IDLE, so that no source remains in RUN. On a clear event:
- All entries are invalidated and both pointers are set to 0.
- A simultaneous write is kept: it is stored in entry 0, Wr_Ptr=1, O_Num=1.
- Lookups in the clear cycle still see pre-clear contents.

## Timing
- Lookup latency 0 cycles; a write is visible through forwarding in the same cycle and through the buffer from the next cycle.
- Flush and slice-end clears take effect at the next edge.
- Reset values: all entries invalid, pointers 0, all FSMs IDLE, End 0, O_Num 0, O_Empty 1, O_Full 0, counters 0.
- While reset is asserted, O_Hit is 0 and O_Src follows case 3 (I_Idx_v[s] ? I_Src[s] : 0).
- If reset is asserted mid-slice, the buffer returns to reset state immediately with no clear pulse.

## Configuration
- BYPASS_BUFF_STAT_EN defined: O_Hit_Cnt and O_Miss_Cnt exist. Each cycle with ~I_Stall:
  - O_Hit_Cnt increments by popcount(O_Hit & I_Idx_v);
  - O_Miss_Cnt increments by popcount(~O_Hit & I_Idx_v);
  - both saturate at 2^32−1 and are cleared by I_Flush.
- BYPASS_BUFF_STAT_EN not defined: both ports and all counter logic are absent; all other behaviour is identical.

## Test plan
- BUFF_SIZE=4. Write indices 1,2,3,4 (data A..D), then write 5:
  - O_Full stays 1, O_Num=4;
  - lookup of 1 misses and returns I_Src;
  - lookup of 5 hits and returns E.
- Write index 7=0x11, then 7=0x22 next cycle: O_Num=1, lookup of 7 returns 0x22.
- I_Valid with index 9=0x55 while I_Idx[0]=9 in the same cycle: O_Src[0]=0x55 and O_Hit[0]=1 in that cycle.
- Slice:
  - source 0 starts with I_Idx=10, I_Slice_Len=3 (End=13); writes fill 3 entries;
  - I_Idx=13 with I_Idx_v=1: next cycle O_Num=0, O_Empty=1;
  - same sequence with I_Stall held during the I_Idx=13 cycle: no clear.
- I_Flush together with a write of index 2: next cycle O_Num=1 and only index 2 hits.
- With BYPASS_BUFF_STAT_EN, NUM_SRC=3: 2 hits and 1 miss per cycle for 10 cycles gives O_Hit_Cnt=20, O_Miss_Cnt=10; a stalled cycle adds nothing.
